// File: rtl/fpu_issue_ctrl.sv
// Operand capture and result sequencing stage in front of the multicycle add/sub datapath.
// Define FPU_NAN_FLAG_EN to add the out_nan result flag.
module fpu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_sub,
  input  logic [31:0] fpu_out,
  input  logic        fpu_zflag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zflag,
`ifdef FPU_NAN_FLAG_EN
  output logic        out_nan,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      fpu_a_q;
  logic [31:0]      fpu_b_q;
  logic             fpu_sub_q;
  logic             out_valid_q;
  logic [31:0]      out_result_q;
  logic             out_zflag_q;
  logic             accept;

  // A finishing result can hand over to the next operation in the same cycle.
  assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != IDLE);

  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_sub    = fpu_sub_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zflag  = out_zflag_q;

`ifdef FPU_NAN_FLAG_EN
  logic out_nan_q;
  logic nan_d;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  assign nan_d   = is_nan(fpu_a_q) | is_nan(fpu_b_q) | is_nan(fpu_out);
  assign out_nan = out_nan_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_nan_q <= 1'b0;
    end else if ((state_q == SETTLE) && (cnt_q == '0)) begin
      out_nan_q <= nan_d;
    end
  end
`endif

  // NOTE: every register below uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_sub_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zflag_q  <= 1'b0;
    end else begin
      if (accept) begin
        fpu_a_q   <= in_a;
        fpu_b_q   <= in_b;
        fpu_sub_q <= in_sub;
        cnt_q     <= CNT_LOAD;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= SETTLE;
        end
        SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            out_result_q <= fpu_out;
            out_zflag_q  <= fpu_zflag;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= accept ? SETTLE : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl; a lookup-table stand-in plays the add/sub datapath.
module tb_fpu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_sub;
  logic [31:0] fpu_out;
  logic        fpu_zflag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zflag;
  logic        busy;
`ifdef FPU_NAN_FLAG_EN
  logic        out_nan;
`endif

  int total = 0;
  int bad   = 0;

  fpu_issue_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sub(fpu_sub),
    .fpu_out(fpu_out), .fpu_zflag(fpu_zflag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zflag(out_zflag),
`ifdef FPU_NAN_FLAG_EN
    .out_nan(out_nan),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in covering only the operand triples the tests use.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    case ({a, b, s})
      {32'h3F800000, 32'h40000000, 1'b0}: return 32'h40400000;
      {32'h40400000, 32'h40400000, 1'b1}: return 32'h00000000;
      {32'h3F800000, 32'h3F800000, 1'b0}: return 32'h40000000;
      {32'h40000000, 32'h40000000, 1'b0}: return 32'h40800000;
      {32'h40800000, 32'h3F800000, 1'b1}: return 32'h40400000;
      {32'h40000000, 32'h3F800000, 1'b1}: return 32'h3F800000;
      {32'h7FC00000, 32'h3F800000, 1'b0}: return 32'h7FC00000;
      default:                            return 32'h0BADF00D;
    endcase
  endfunction

  assign fpu_out   = fpu_model(fpu_a, fpu_b, fpu_sub);
  assign fpu_zflag = (fpu_out[30:0] == 31'd0);

  // Presents an op at the current negedge and returns at the negedge after its accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    total++; if (!in_ready) begin bad++; $display("FAIL send_timeout: in_ready=%0b required 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_cyc);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    total++; if (cyc !== exp_cyc) begin bad++; $display("FAIL %s_latency: got %0d cycles required %0d", name, cyc, exp_cyc); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    total++; if ({out_valid, busy, out_zflag} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b required 000", {out_valid, busy, out_zflag}); end
    total++; if ({fpu_a, fpu_b, fpu_sub, out_result} !== 97'd0) begin bad++; $display("FAIL rst_regs: got %h required 0", {fpu_a, fpu_b, fpu_sub, out_result}); end
`ifdef FPU_NAN_FLAG_EN
    total++; if (out_nan !== 1'b0) begin bad++; $display("FAIL rst_nan: got %0b required 0", out_nan); end
`endif
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, 1'b0);
    total++; if ({busy, out_valid} !== 2'b10) begin bad++; $display("FAIL add_settle: busy,out_valid=%b required 10", {busy, out_valid}); end
    total++; if (fpu_a !== 32'h3F800000 || fpu_b !== 32'h40000000 || fpu_sub !== 1'b0) begin bad++; $display("FAIL add_operands: got %h %h %0b", fpu_a, fpu_b, fpu_sub); end
    wait_valid("add", 2);
    total++; if (out_result !== 32'h40400000 || out_zflag !== 1'b0) begin bad++; $display("FAIL add_result: got %h z=%0b required 40400000 z=0", out_result, out_zflag); end
    @(negedge clk);
    total++; if ({busy, out_valid} !== 2'b00) begin bad++; $display("FAIL add_consume: busy,out_valid=%b required 00", {busy, out_valid}); end
  endtask

  task automatic test_sub_zero;
    send(32'h40400000, 32'h40400000, 1'b1);
    wait_valid("sub", 2);
    total++; if (out_result !== 32'h00000000 || out_zflag !== 1'b1) begin bad++; $display("FAIL sub_result: got %h z=%0b required 00000000 z=1", out_result, out_zflag); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send(32'h40000000, 32'h40000000, 1'b0);
    wait_valid("bp_first", 2);
    in_a = 32'h40000000; in_b = 32'h3F800000; in_sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_hs[%0d]: in_ready=%0b out_valid=%0b required 0 1", i, in_ready, out_valid); end
      total++; if (out_result !== 32'h40800000) begin bad++; $display("FAIL bp_hold_result[%0d]: got %h required 40800000", i, out_result); end
      total++; if (fpu_b !== 32'h40000000 || fpu_sub !== 1'b0) begin bad++; $display("FAIL bp_no_load[%0d]: fpu_b=%h sub=%0b required 40000000 0", i, fpu_b, fpu_sub); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %0b required 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if ({busy, out_valid} !== 2'b10 || fpu_b !== 32'h3F800000 || fpu_sub !== 1'b1) begin bad++; $display("FAIL bp_second_load: busy,valid=%b fpu_b=%h sub=%0b", {busy, out_valid}, fpu_b, fpu_sub); end
    wait_valid("bp_second", 2);
    total++; if (out_result !== 32'h3F800000) begin bad++; $display("FAIL bp_second_result: got %h required 3F800000", out_result); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] op_a [4] = '{32'h40400000, 32'h3F800000, 32'h40000000, 32'h40800000};
    logic [31:0] op_b [4] = '{32'h40400000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    logic        op_s [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_r [4] = '{32'h00000000, 32'h40000000, 32'h40800000, 32'h40400000};
    int idx, res, last_t, t;
    idx = 0; res = 0; last_t = 0; t = 0;
    out_ready = 1'b1;
    while (res < 4 && t < 60) begin
      if (out_valid) begin
        total++; if (out_result !== exp_r[res]) begin bad++; $display("FAIL b2b_result[%0d]: got %h required %h", res, out_result, exp_r[res]); end
        if (res > 0) begin
          total++; if (t - last_t !== 3) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d required 3", res, t - last_t); end
        end
        last_t = t;
        res++;
      end
      if (idx < 4) begin
        in_a = op_a[idx]; in_b = op_b[idx]; in_sub = op_s[idx]; in_valid = 1'b1;
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    total++; if (res !== 4) begin bad++; $display("FAIL b2b_count: got %0d results required 4", res); end
    @(negedge clk);
    total++; if ({busy, out_valid} !== 2'b00) begin bad++; $display("FAIL b2b_drain: busy,out_valid=%b required 00", {busy, out_valid}); end
  endtask

  task automatic test_reset_mid_op;
    send(32'h3F800000, 32'h40000000, 1'b0);
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready: got %0b required 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    total++; if ({out_valid, busy, out_zflag} !== 3'b000) begin bad++; $display("FAIL mid_rst_flags: got %b required 000", {out_valid, busy, out_zflag}); end
    total++; if ({fpu_a, fpu_b, fpu_sub, out_result} !== 97'd0) begin bad++; $display("FAIL mid_rst_regs: got %h required 0", {fpu_a, fpu_b, fpu_sub, out_result}); end
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_no_result: out_valid=%0b required 0", out_valid); end
    send(32'h3F800000, 32'h40000000, 1'b0);
    wait_valid("post_rst", 2);
    total++; if (out_result !== 32'h40400000) begin bad++; $display("FAIL post_rst_result: got %h required 40400000", out_result); end
    @(negedge clk);
  endtask

`ifdef FPU_NAN_FLAG_EN
  task automatic test_nan;
    send(32'h7FC00000, 32'h3F800000, 1'b0);
    wait_valid("nan", 2);
    total++; if (out_nan !== 1'b1) begin bad++; $display("FAIL nan_set: got %0b required 1", out_nan); end
    @(negedge clk);
    send(32'h3F800000, 32'h40000000, 1'b0);
    wait_valid("nan_clear", 2);
    total++; if (out_nan !== 1'b0 || out_result !== 32'h40400000) begin bad++; $display("FAIL nan_clear: nan=%0b result=%h required 0 40400000", out_nan, out_result); end
    @(negedge clk);
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset;
    test_add;
    test_sub_zero;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_op;
`ifdef FPU_NAN_FLAG_EN
    test_nan;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Sequencing and capture stage that sits directly upstream of the combinational add/sub datapath, FPU_Wrapper. It accepts one operation (A, B, sub) per valid/ready handshake and holds the operands stable in registers that drive the datapath. It waits a programmable number of settle cycles, because the datapath is a multicycle path, then captures OUT and zflag into an output register. The result is presented to the consumer under a second valid/ready handshake.

Parameters:
SETTLE_CYCLES, 2, cycles between operand register load and result capture; legal range 1..15
CNT_W, 4, width of settle down-counter; must satisfy 2**CNT_W > SETTLE_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream operation valid
in_ready  output  1  block can accept an operation this cycle
in_a  input  32  operand A, IEEE-754 single
in_b  input  32  operand B, IEEE-754 single
in_sub  input  1  1 = A-B, 0 = A+B
fpu_a  output  32  registered operand A to datapath
fpu_b  output  32  registered operand B to datapath
fpu_sub  output  1  registered sub to datapath
fpu_out  input  32  datapath result
fpu_zflag  input  1  datapath zero flag
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  downstream accepts the result
out_result  output  32  captured result
out_zflag  output  1  captured zero flag
busy  output  1  high in SETTLE or DONE

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, counter=0.
  - fpu_a, fpu_b, fpu_sub, out_result, out_zflag, out_valid all cleared to 0.
  - in_ready=0 while rst_n=0.
- Reset is synchronous: it takes effect only on a clk edge. Reset asserted in any state aborts the operation in flight; no result is emitted.
- States are IDLE, SETTLE, DONE. busy = (state != IDLE).
- in_ready = rst_n & (state==IDLE | (state==DONE & out_ready)). It is combinational from state and out_ready.
- Accept = in_valid & in_ready:
  - Load fpu_a/fpu_b/fpu_sub from in_a/in_b/in_sub.
  - counter = SETTLE_CYCLES-1.
  - state -> SETTLE.
- SETTLE:
  - If counter != 0: decrement.
  - If counter == 0: out_result<=fpu_out, out_zflag<=fpu_zflag, out_valid<=1, state -> DONE.
- Latency: operation accepted at edge N gives out_valid=1 after edge N+SETTLE_CYCLES.
- DONE:
  - out_valid=1; out_result and out_zflag are held stable until the handshake completes.
  - out_ready=1 with no accept: out_valid<=0, state -> IDLE.
  - out_ready=1 with a simultaneous accept: result consumed and new operands loaded in the same edge; out_valid<=0, state -> SETTLE. Sustained throughput is one op per SETTLE_CYCLES+1 cycles.
  - out_ready=0: hold; in_ready=0, so new in_valid is ignored.
- fpu_a/fpu_b/fpu_sub change only on accept. They remain stable through SETTLE and DONE.
- out_result/out_zflag change only on the capture edge.
- in_valid during SETTLE is not accepted. Upstream must hold it, per the handshake rule that valid persists until ready.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: FPU_NAN_FLAG_EN.
- When defined:
  - Adds output port out_nan (1 bit), captured on the same edge as out_result and cleared by reset.
  - out_nan = 1 when fpu_a or fpu_b has exp==8'hFF and mant!=0, or when fpu_out does.
- When undefined: the port is absent and no detection logic is built.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, then in_a=0x3F800000, in_b=0x40000000, in_sub=0, out_ready=1 -> out_valid high exactly 2 cycles after accept; out_result=0x40400000, out_zflag=0.
2. in_a=0x40400000, in_b=0x40400000, in_sub=1 -> out_result=0x00000000, out_zflag=1.
3. Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid held high carrying a second op:
   - out_result stays stable; in_ready=0 throughout; second op not loaded.
   - Raise out_ready -> second op accepted on the same edge; its result appears 2 cycles later.
4. Back-to-back: 4 ops with in_valid and out_ready always high -> one result every 3 cycles, in order, no op dropped or duplicated.
5. Reset mid-op: assert rst_n=0 one cycle into SETTLE -> after reset, out_valid=0, busy=0, all outputs 0; next op completes normally.
6. FPU_NAN_FLAG_EN build: in_a=0x7FC00000, in_b=0x3F800000 -> out_nan=1. Then 1.0+2.0 -> out_nan=0.
